// File: rtl/chunked_addsub_if.sv
// rtl/chunked_addsub_if.sv - operand/result handshake bundle for chunked_addsub
interface chunked_addsub_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sub;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         c_out;
    logic         ovf;
    logic         zero;

    modport master (
        output in_valid, a, b, sub, c_in, out_ready,
        input  in_ready, out_valid, result, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, c_in, out_ready,
        output in_ready, out_valid, result, c_out, ovf, zero
    );
endinterface

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle adder/subtractor, K bits per cycle
module chunked_addsub #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic           clk,
    input  logic           rst,
    chunked_addsub_if.slave bus
);
    localparam int CHUNKS = N / K;
    localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    if ((N % K) != 0) begin : g_bad_k
        $error("chunked_addsub: N must be a multiple of K");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [N-1:0]     a_q, b_q, result_q, result_next;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic             c_out_q, ovf_q, zero_q;
    logic [K-1:0]     a_chunk, b_chunk;
    logic [K:0]       chunk_sum;
    logic             carry_into_msb;
    logic             last_chunk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = BUSY;
            BUSY:    if (last_chunk)    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // b is stored already inverted for subtract, so the chunk adder never sees the mode bit
    always_comb begin
        a_chunk        = a_q[idx*K +: K];
        b_chunk        = b_q[idx*K +: K];
        chunk_sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{K{1'b0}}, carry_q};
        carry_into_msb = chunk_sum[K-1] ^ a_chunk[K-1] ^ b_chunk[K-1];
        last_chunk     = (idx == LAST_IDX);
        result_next    = result_q;
        result_next[idx*K +: K] = chunk_sum[K-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.c_in;
                        idx     <= '0;
                    end
                end
                BUSY: begin
                    result_q <= result_next;
                    carry_q  <= chunk_sum[K];
                    idx      <= idx + 1'b1;
                    if (last_chunk) begin
                        c_out_q <= chunk_sum[K];
                        ovf_q   <= chunk_sum[K] ^ carry_into_msb;
                        zero_q  <= (result_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - directed self-checking bench for chunked_addsub
module tb_chunked_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    chunked_addsub_if #(.N(32)) ifm ();
    chunked_addsub_if #(.N(32)) if_k32 ();
    chunked_addsub_if #(.N(32)) if_k1 ();
    chunked_addsub_if #(.N(16)) if_n16 ();

    chunked_addsub #(.N(32), .K(8))  dut     (.clk(clk), .rst(rst), .bus(ifm));
    chunked_addsub #(.N(32), .K(32)) dut_k32 (.clk(clk), .rst(rst), .bus(if_k32));
    chunked_addsub #(.N(32), .K(1))  dut_k1  (.clk(clk), .rst(rst), .bus(if_k1));
    chunked_addsub #(.N(16), .K(4))  dut_n16 (.clk(clk), .rst(rst), .bus(if_n16));

    task automatic op_main(input logic [31:0] av, input logic [31:0] bv, input logic s,
                           input logic c, output int lat);
        @(negedge clk);
        ifm.a = av; ifm.b = bv; ifm.sub = s; ifm.c_in = c; ifm.in_valid = 1'b1;
        @(posedge clk); #1;
        ifm.in_valid = 1'b0;
        lat = 0;
        while (!ifm.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_main();
        @(negedge clk);
        ifm.out_ready = 1'b1;
        @(posedge clk); #1;
        ifm.out_ready = 1'b0;
        tests_run++;
        if (ifm.in_ready !== 1'b1 || ifm.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL release: in_ready=%b out_valid=%b expected 1/0", ifm.in_ready, ifm.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tests_run++;
        if ({ifm.in_ready, ifm.out_valid, ifm.result, ifm.c_out, ifm.ovf, ifm.zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h c=%b o=%b z=%b expected 1 0 0 0 0 0",
                     ifm.in_ready, ifm.out_valid, ifm.result, ifm.c_out, ifm.ovf, ifm.zero);
        end
    endtask

    task automatic check_main(input string name, input int lat, input logic [31:0] er,
                              input logic ec, input logic eo, input logic ez);
        tests_run++;
        if (lat !== 4) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d expected 4", name, lat);
        end
        tests_run++;
        if ({ifm.result, ifm.c_out, ifm.ovf, ifm.zero} !== {er, ec, eo, ez}) begin
            tests_failed++;
            $display("FAIL %s_value: got res=%h c=%b o=%b z=%b expected res=%h c=%b o=%b z=%b",
                     name, ifm.result, ifm.c_out, ifm.ovf, ifm.zero, er, ec, eo, ez);
        end
        tests_run++;
        if (ifm.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_in_ready_done: got %b expected 0", name, ifm.in_ready);
        end
    endtask

    task automatic test_add_wrap();
        int lat;
        op_main(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        check_main("add_wrap", lat, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        release_main();
    endtask

    task automatic test_subtract();
        int lat;
        op_main(32'h5, 32'h3, 1'b1, 1'b1, lat);
        check_main("sub_5_3", lat, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        release_main();
        op_main(32'h3, 32'h5, 1'b1, 1'b1, lat);
        check_main("sub_3_5", lat, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        release_main();
    endtask

    task automatic test_overflow();
        int lat;
        op_main(32'h8000_0000, 32'h1, 1'b1, 1'b1, lat);
        check_main("ovf_sub", lat, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        release_main();
        op_main(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        check_main("ovf_add", lat, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        release_main();
    endtask

    task automatic test_backpressure();
        int lat;
        op_main(32'h1, 32'h2, 1'b0, 1'b0, lat);
        check_main("bp_op", lat, 32'h3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ifm.a = $urandom; ifm.b = $urandom; ifm.sub = i[0]; ifm.c_in = i[1];
            ifm.in_valid = ~i[0];
            @(posedge clk); #1;
            tests_run++;
            if ({ifm.out_valid, ifm.in_ready, ifm.result, ifm.c_out, ifm.ovf, ifm.zero} !==
                {1'b1, 1'b0, 32'h3, 3'b000}) begin
                tests_failed++;
                $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b res=%h c=%b o=%b z=%b expected 1 0 3 0 0 0",
                         i, ifm.out_valid, ifm.in_ready, ifm.result, ifm.c_out, ifm.ovf, ifm.zero);
            end
        end
        ifm.in_valid = 1'b0;
        release_main();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen;
        @(negedge clk);
        ifm.a = 32'h1234_5678; ifm.b = 32'h1111_1111; ifm.sub = 1'b0; ifm.c_in = 1'b0;
        ifm.in_valid = 1'b1;
        @(posedge clk); #1;
        ifm.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if ({ifm.in_ready, ifm.out_valid, ifm.result, ifm.c_out, ifm.ovf, ifm.zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_mid_op_state: got rdy=%b vld=%b res=%h c=%b o=%b z=%b expected 1 0 0 0 0 0",
                     ifm.in_ready, ifm.out_valid, ifm.result, ifm.c_out, ifm.ovf, ifm.zero);
        end
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ifm.out_valid) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_op_no_valid: got %0d out_valid cycles expected 0", seen);
        end
        op_main(32'h1, 32'h2, 1'b0, 1'b0, lat);
        check_main("after_reset", lat, 32'h3, 1'b0, 1'b0, 1'b0);
        release_main();
    endtask

    task automatic test_sweep_k32();
        logic [31:0] av, bv, bb, er;
        logic [32:0] s;
        logic        sb, c, eo;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            av = (i == 0) ? 32'h8000_0000 : $urandom;
            bv = (i == 0) ? 32'h8000_0000 : $urandom;
            sb = i[0]; c = i[1];
            bb = sb ? ~bv : bv;
            s  = {1'b0, av} + {1'b0, bb} + {32'h0, c};
            er = s[31:0];
            eo = (av[31] == bb[31]) && (er[31] != av[31]);
            @(negedge clk);
            if_k32.a = av; if_k32.b = bv; if_k32.sub = sb; if_k32.c_in = c; if_k32.in_valid = 1'b1;
            @(posedge clk); #1;
            if_k32.in_valid = 1'b0;
            lat = 0;
            while (!if_k32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            tests_run++;
            if ({lat, if_k32.result, if_k32.c_out, if_k32.ovf, if_k32.zero} !== {32'd1, er, s[32], eo, (er == 32'h0)}) begin
                tests_failed++;
                $display("FAIL sweep_k32_%0d: got lat=%0d res=%h c=%b o=%b z=%b expected lat=1 res=%h c=%b o=%b",
                         i, lat, if_k32.result, if_k32.c_out, if_k32.ovf, if_k32.zero, er, s[32], eo);
            end
            @(negedge clk); if_k32.out_ready = 1'b1;
            @(posedge clk); #1; if_k32.out_ready = 1'b0;
        end
    endtask

    task automatic test_sweep_k1();
        logic [31:0] av, bv, bb, er;
        logic [32:0] s;
        logic        sb, c, eo;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            av = (i == 0) ? 32'h7FFF_FFFF : $urandom;
            bv = (i == 0) ? 32'h0000_0001 : $urandom;
            sb = i[1]; c = i[0];
            bb = sb ? ~bv : bv;
            s  = {1'b0, av} + {1'b0, bb} + {32'h0, c};
            er = s[31:0];
            eo = (av[31] == bb[31]) && (er[31] != av[31]);
            @(negedge clk);
            if_k1.a = av; if_k1.b = bv; if_k1.sub = sb; if_k1.c_in = c; if_k1.in_valid = 1'b1;
            @(posedge clk); #1;
            if_k1.in_valid = 1'b0;
            lat = 0;
            while (!if_k1.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            tests_run++;
            if ({lat, if_k1.result, if_k1.c_out, if_k1.ovf, if_k1.zero} !== {32'd32, er, s[32], eo, (er == 32'h0)}) begin
                tests_failed++;
                $display("FAIL sweep_k1_%0d: got lat=%0d res=%h c=%b o=%b z=%b expected lat=32 res=%h c=%b o=%b",
                         i, lat, if_k1.result, if_k1.c_out, if_k1.ovf, if_k1.zero, er, s[32], eo);
            end
            @(negedge clk); if_k1.out_ready = 1'b1;
            @(posedge clk); #1; if_k1.out_ready = 1'b0;
        end
    endtask

    task automatic test_sweep_n16();
        logic [15:0] av, bv, bb, er;
        logic [16:0] s;
        logic        sb, c, eo;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            av = (i == 0) ? 16'h1234 : 16'($urandom);
            bv = (i == 0) ? 16'h1234 : 16'($urandom);
            sb = (i == 0) ? 1'b1 : i[0];
            c  = (i == 0) ? 1'b1 : i[1];
            bb = sb ? ~bv : bv;
            s  = {1'b0, av} + {1'b0, bb} + {16'h0, c};
            er = s[15:0];
            eo = (av[15] == bb[15]) && (er[15] != av[15]);
            @(negedge clk);
            if_n16.a = av; if_n16.b = bv; if_n16.sub = sb; if_n16.c_in = c; if_n16.in_valid = 1'b1;
            @(posedge clk); #1;
            if_n16.in_valid = 1'b0;
            lat = 0;
            while (!if_n16.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
            tests_run++;
            if ({lat, if_n16.result, if_n16.c_out, if_n16.ovf, if_n16.zero} !== {32'd4, er, s[16], eo, (er == 16'h0)}) begin
                tests_failed++;
                $display("FAIL sweep_n16_%0d: got lat=%0d res=%h c=%b o=%b z=%b expected lat=4 res=%h c=%b o=%b",
                         i, lat, if_n16.result, if_n16.c_out, if_n16.ovf, if_n16.zero, er, s[16], eo);
            end
            @(negedge clk); if_n16.out_ready = 1'b1;
            @(posedge clk); #1; if_n16.out_ready = 1'b0;
        end
    endtask

    initial begin
        ifm.in_valid = 1'b0;    ifm.a = '0;    ifm.b = '0;    ifm.sub = 1'b0;    ifm.c_in = 1'b0;    ifm.out_ready = 1'b0;
        if_k32.in_valid = 1'b0; if_k32.a = '0; if_k32.b = '0; if_k32.sub = 1'b0; if_k32.c_in = 1'b0; if_k32.out_ready = 1'b0;
        if_k1.in_valid = 1'b0;  if_k1.a = '0;  if_k1.b = '0;  if_k1.sub = 1'b0;  if_k1.c_in = 1'b0;  if_k1.out_ready = 1'b0;
        if_n16.in_valid = 1'b0; if_n16.a = '0; if_n16.b = '0; if_n16.sub = 1'b0; if_n16.c_in = 1'b0; if_n16.out_ready = 1'b0;
        test_reset();
        test_add_wrap();
        test_subtract();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_sweep_k32();
        test_sweep_k1();
        test_sweep_n16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/chunked_addsub.md
CHUNKED_ADDSUB -- requirements
Module: chunked_addsub

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter K, default 8, meaning bits processed per cycle; N SHALL be a multiple of K, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 a  input  N  operand A.
REQ-008 b  input  N  operand B.
REQ-009 sub  input  1  0 = add, 1 = subtract (B inverted).
REQ-010 c_in  input  1  carry-in to bit 0.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  N  sum/difference.
REQ-014 c_out  output  1  carry out of bit N-1.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  result equals 0.

Function
REQ-017 Arithmetic SHALL be result = (a + (sub ? ~b : b) + c_in) mod 2^N; subtract with c_in=1 yields a-b.
REQ-018 c_out SHALL be the carry out of bit N-1; ovf SHALL be carry into bit N-1 XOR carry out of bit N-1; zero SHALL be (result == 0).
REQ-019 The FSM SHALL have states IDLE, BUSY and DONE, and SHALL reset to IDLE.
REQ-020 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-021 IDLE: when in_valid is 1 at an edge, the block SHALL latch a, b (inverted if sub), c_in and sub, clear the chunk index, and go to BUSY.
REQ-022 BUSY: each cycle, the block SHALL add chunk [idx*K +: K] of the latched operands with the registered carry, write that result slice, register the chunk carry, and increment idx.
REQ-023 BUSY: the block SHALL go to DONE after the cycle that processes chunk N/K-1.
REQ-024 Latency: for acceptance at edge E, out_valid SHALL rise after edge E+N/K; with K=N, it SHALL rise after E+1.
REQ-025 The carry into bit N-1, needed for ovf, SHALL be captured during the final chunk.
REQ-026 Changes on a, b, sub, c_in and in_valid during BUSY or DONE SHALL be ignored.
REQ-027 DONE: result, c_out, ovf and zero SHALL hold stable while out_ready is 0, for any number of cycles.
REQ-028 DONE: when out_ready is 1 at an edge, the block SHALL go to IDLE, so out_valid falls and in_ready rises on the next cycle.
REQ-029 A new operation SHALL be accepted no earlier than one cycle after the result handshake (throughput one op per N/K+2 cycles).
REQ-030 out_ready seen outside DONE SHALL have no effect.
REQ-031 The block SHALL have no combinational path from inputs to outputs; all outputs SHALL come from registers or FSM state.

Reset
REQ-032 With rst high at an edge, the block SHALL go to IDLE and set result=0, c_out=0, ovf=0, zero=0, out_valid=0, idx=0 and the carry register to 0; in_ready SHALL be 1 from the next cycle.
REQ-033 rst SHALL take priority over every other input, including in_valid in the same cycle.
REQ-034 rst during BUSY or DONE SHALL discard the operation with no out_valid pulse.

Verification
REQ-035 Add wrap (N=32, K=8): a=FFFFFFFF, b=00000001, sub=0, c_in=0 -> out_valid 4 cycles after accept, result=00000000, c_out=1, ovf=0, zero=1.
REQ-036 Subtract: a=00000005, b=00000003, sub=1, c_in=1 -> result=00000002, c_out=1, ovf=0, zero=0; then a=3, b=5 -> result=FFFFFFFE, c_out=0.
REQ-037 Signed overflow: a=80000000, b=00000001, sub=1, c_in=1 -> result=7FFFFFFF, ovf=1, c_out=1; a=7FFFFFFF, b=1, add, c_in=0 -> result=80000000, ovf=1, c_out=0.
REQ-038 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling a, b and in_valid -> outputs unchanged, in_ready=0; raise out_ready -> in_ready=1 next cycle.
REQ-039 Reset mid-op: assert rst on the 2nd BUSY cycle -> all outputs 0 and in_ready=1 next cycle, no out_valid; next operation 1+2 -> result=3.
REQ-040 Parameter sweep: K=32, K=1 and N=16, K=4 on random vectors against the REQ-017/018 reference model -> exact match, latency N/K.
